// File: rtl/bsg_mux_bitwise_pipe.sv
// Pipelined per-bit mux: each output bit picks one of els_p words via its own select field.
// The result passes through a 2-entry valid/ready -> valid/yumi buffer; BSG_MUX_BITWISE_PIPE_COUNT_EN adds a saturating beat counter.
module bsg_mux_bitwise_pipe #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned els_p         = 2,
  parameter int unsigned invert_p      = 1,
  parameter int unsigned count_width_p = 16,
  localparam int unsigned lg_els_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [els_p*width_p-1:0]       data_i,
  input  logic [width_p*lg_els_lp-1:0]   sel_i,
  input  logic                           v_i,
  output logic                           ready_o,
  output logic [width_p-1:0]             data_o,
  output logic                           v_o,
  input  logic                           yumi_i
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
  , output logic [count_width_p-1:0]     count_o
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e             state_r;
  logic [width_p-1:0] mux_res;
  logic [width_p-1:0] head_r;
  logic [width_p-1:0] tail_r;
  logic               accept;
  logic               pop;

  // Out-of-range selects match no word, so the OR-reduction yields 0 before inversion.
  for (genvar b = 0; b < width_p; b++) begin : g_bit
    logic [lg_els_lp-1:0] sel;
    logic [els_p-1:0]     hit;
    assign sel = sel_i[b*lg_els_lp +: lg_els_lp];
    for (genvar k = 0; k < els_p; k++) begin : g_el
      assign hit[k] = (sel == lg_els_lp'(k)) & data_i[k*width_p+b];
    end
    assign mux_res[b] = (invert_p != 0) ? ~(|hit) : (|hit);
  end

  assign ready_o = (state_r != FULL) & ~reset_i;
  assign v_o     = (state_r != EMPTY);
  assign data_o  = head_r;
  assign accept  = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      unique case (state_r)
        EMPTY: begin
          if (accept) begin
            head_r  <= mux_res;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_r <= mux_res;
          end else if (accept) begin
            tail_r  <= mux_res;
            state_r <= FULL;
          end else if (pop) begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_r  <= tail_r;
            state_r <= ONE;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end

`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (pop && (count_o != '1)) begin
      count_o <= count_o + count_width_p'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mux_bitwise_pipe.sv
// Randomized bench for bsg_mux_bitwise_pipe: three configurations checked every cycle against a queue model.
// Counter checks are compiled in when BSG_MUX_BITWISE_PIPE_COUNT_EN is defined.
module tb_bsg_mux_bitwise_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v;
  logic        yumi;
  logic [31:0] da;
  logic [15:0] sa;
  logic [47:0] db;
  logic [31:0] sb;

  logic        a_ready, a_v, b_ready, b_v, c_ready, c_v;
  logic [15:0] a_data, b_data, c_data;
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt, c_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bsg_mux_bitwise_pipe #(.width_p(16), .els_p(2), .invert_p(1), .count_width_p(16)) u_a (
    .clk_i(clk), .reset_i(reset), .data_i(da), .sel_i(sa), .v_i(v), .ready_o(a_ready),
    .data_o(a_data), .v_o(a_v), .yumi_i(yumi)
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    , .count_o(a_cnt)
`endif
  );

  bsg_mux_bitwise_pipe #(.width_p(16), .els_p(3), .invert_p(0), .count_width_p(4)) u_b (
    .clk_i(clk), .reset_i(reset), .data_i(db), .sel_i(sb), .v_i(v), .ready_o(b_ready),
    .data_o(b_data), .v_o(b_v), .yumi_i(yumi)
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    , .count_o(b_cnt)
`endif
  );

  bsg_mux_bitwise_pipe #(.width_p(16), .els_p(3), .invert_p(1), .count_width_p(4)) u_c (
    .clk_i(clk), .reset_i(reset), .data_i(db), .sel_i(sb), .v_i(v), .ready_o(c_ready),
    .data_o(c_data), .v_o(c_v), .yumi_i(yumi)
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    , .count_o(c_cnt)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // True-polarity mux result from the selection rule, by plain shifts.
  function automatic logic [15:0] pick(input logic [47:0] words, input logic [31:0] sels,
                                       input int unsigned n_words, input int unsigned lg);
    logic [15:0] r;
    logic [47:0] tmp;
    int unsigned s;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      s = (sels >> (b * lg)) & ((32'd1 << lg) - 1);
      tmp = words >> (s * 16 + b);
      r[b] = (s < n_words) ? tmp[0] : 1'b0;
    end
    return r;
  endfunction

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int unsigned consumed = 0;

  always @(posedge clk) begin
    bit room;
    room = (qa.size() < 2);
    if (reset) begin
      qa.delete();
      qb.delete();
      consumed = 0;
    end else begin
      chk("yumi_legal", {31'd0, yumi && (qa.size() == 0)}, 32'd0);
      if (yumi && qa.size() > 0) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        consumed++;
      end
      if (v && room) begin
        qa.push_back(~pick({16'h0, da}, {16'h0, sa}, 2, 1));
        qb.push_back(pick(db, sb, 3, 2));
      end
    end
  end

  always @(negedge clk) begin
    logic exp_v, exp_rdy;
    exp_v   = (qa.size() != 0);
    exp_rdy = !reset && (qa.size() < 2);
    chk("a_v", {31'd0, a_v}, {31'd0, exp_v});
    chk("b_v", {31'd0, b_v}, {31'd0, exp_v});
    chk("c_v", {31'd0, c_v}, {31'd0, exp_v});
    chk("a_ready", {31'd0, a_ready}, {31'd0, exp_rdy});
    chk("b_ready", {31'd0, b_ready}, {31'd0, exp_rdy});
    chk("c_ready", {31'd0, c_ready}, {31'd0, exp_rdy});
    if (exp_v) begin
      chk("a_data", {16'd0, a_data}, {16'd0, qa[0]});
      chk("b_data", {16'd0, b_data}, {16'd0, qb[0]});
      chk("c_data", {16'd0, c_data}, {16'd0, ~qb[0]});
    end
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    chk("a_count", {16'd0, a_cnt}, (consumed > 65535) ? 32'd65535 : consumed);
    chk("b_count", {28'd0, b_cnt}, (consumed > 15) ? 32'd15 : consumed);
    chk("c_count", {28'd0, c_cnt}, (consumed > 15) ? 32'd15 : consumed);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    da = $urandom;
    sa = 16'($urandom);
    db = {16'($urandom), $urandom};
    sb = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    v     = 1'b1;
    yumi  = 1'b0;
    randomize_inputs();

    // Reset with v_i high: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rst_v", {31'd0, a_v}, 32'd0);
      chk("rst_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_data", {16'd0, a_data}, 32'd0);
    end
    reset = 1'b0;
    v     = 1'b0;
    step();
    #1;
    chk("post_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_v", {31'd0, a_v}, 32'd0);

    // Known select pattern; B/C see every select field = 3 (out of range).
    da = {16'hF0F0, 16'h00FF};
    sa = 16'hAAAA;
    db = {16'h1234, 16'hF0F0, 16'h00FF};
    sb = 32'hFFFF_FFFF;
    v  = 1'b1;
    step();
    v = 1'b0;
    #1;
    chk("basic_v", {31'd0, a_v}, 32'd1);
    chk("basic_a", {16'd0, a_data}, 32'h0000_5F0A);
    chk("oor_noinv", {16'd0, b_data}, 32'h0000_0000);
    chk("oor_inv", {16'd0, c_data}, 32'h0000_FFFF);
    yumi = 1'b1;
    step();
    yumi = 1'b0;

    // Backpressure: A, B, C offered with no consumer.
    v = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    randomize_inputs();
    #1;
    chk("bp_full_ready", {31'd0, a_ready}, 32'd0);
    step();
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    #1;
    chk("bp_ready_back", {31'd0, a_ready}, 32'd1);
    step();
    v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      yumi = (qa.size() > 0);
      step();
    end
    yumi = 1'b0;

    // Streaming 100 beats from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    v = 1'b1;
    randomize_inputs();
    step();
    yumi = 1'b1;
    for (int i = 0; i < 99; i++) begin
      randomize_inputs();
      step();
    end
    v = 1'b0;
    step();
    yumi = 1'b0;
    #1;
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    chk("stream_count", {16'd0, a_cnt}, 32'd100);
    chk("sat_count", {28'd0, b_cnt}, 32'hF);
`endif
    v = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    v = 1'b0;
    reset = 1'b1;
    step();
    #1;
    chk("midrst_v", {31'd0, a_v}, 32'd0);
`ifdef BSG_MUX_BITWISE_PIPE_COUNT_EN
    chk("midrst_count", {16'd0, a_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      v     = $urandom_range(0, 1) == 1;
      yumi  = (qa.size() > 0) && ($urandom_range(0, 3) != 0);
      randomize_inputs();
      step();
    end
    reset = 1'b0;
    v     = 1'b0;
    yumi  = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
